// File: rtl/cdb_arbiter.sv
// Common data bus arbiter.
//
// Each cycle at most one functional unit that has a finished result is
// granted the CDB by round-robin. The granted FU's ROB tag, freed RS entry
// and value are registered and broadcast in the following cycle.
//
// Ports:
//   clock        system clock
//   reset        asynchronous, active-high reset
//   req          per-FU result-ready request
//   req_tag      packed ROB tags, FU i at [i*TAG_W +: TAG_W]
//   req_rs_tag   packed RS entry tags freed by each result
//   req_value    packed result data
//   flush        ROB squash; suppresses the grant and the next broadcast
//   grant        combinational one-hot (or zero) grant
//   cdb_valid    registered broadcast valid
//   cdb_tag      registered broadcast ROB tag
//   cdb_rs_tag   registered broadcast RS entry tag
//   cdb_value    registered broadcast data
//   protocol_err sticky requester-protocol violation flag
module cdb_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TAG_W   = 3,
    parameter int unsigned RS_W    = 3,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*RS_W-1:0]   req_rs_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_value,
    input  logic                      flush,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [RS_W-1:0]           cdb_rs_tag,
    output logic [DATA_W-1:0]         cdb_value,
    output logic                      protocol_err
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // All-ones RS tag marks "no entry".
    localparam logic [RS_W-1:0] RS_INVALID = '1;

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_idx;
    logic               win_valid;
    logic [TAG_W-1:0]   sel_tag;
    logic [RS_W-1:0]    sel_rs_tag;
    logic [DATA_W-1:0]  sel_value;
    logic [NUM_REQ-1:0] req_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               flush_q;
    logic               err_q;
    logic               err_hit;

    // Round-robin search starting at ptr_q, wrapping around.
    always_comb begin : select
        int unsigned cand;
        cand      = 0;
        win_valid = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr_q) + k) % NUM_REQ;
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
        if (flush) begin
            win_valid = 1'b0;
        end
    end

    always_comb begin : grant_out
        grant = '0;
        if (win_valid) begin
            grant[win_idx] = 1'b1;
        end
    end

    always_comb begin : fields
        int unsigned w;
        w          = 32'(win_idx);
        sel_tag    = req_tag[w*TAG_W +: TAG_W];
        sel_rs_tag = req_rs_tag[w*RS_W +: RS_W];
        sel_value  = req_value[w*DATA_W +: DATA_W];
    end

    always_comb begin : next_ptr
        ptr_d = ptr_q;
        if (win_valid) begin
            if (win_idx == PTR_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_idx + PTR_W'(1);
            end
        end
    end

    // A zero ROB tag is illegal on a request; a request that disappears without a
    // grant (and without a squash releasing it) breaks the hold contract.
    always_comb begin : proto
        err_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req[i] && (req_tag[i*TAG_W +: TAG_W] == '0)) begin
                err_hit = 1'b1;
            end
            if (req_q[i] && !grant_q[i] && !req[i] && !flush_q) begin
                err_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_rs_tag <= RS_INVALID;
            cdb_value  <= '0;
            req_q      <= '0;
            grant_q    <= '0;
            flush_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            cdb_valid <= win_valid;
            if (win_valid) begin
                cdb_tag    <= sel_tag;
                cdb_rs_tag <= sel_rs_tag;
                cdb_value  <= sel_value;
            end
            req_q   <= req;
            grant_q <= grant;
            flush_q <= flush;
            if (err_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign protocol_err = err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
    localparam int NR = 4;
    localparam int TW = 3;
    localparam int RW = 3;
    localparam int DW = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR*TW-1:0]  req_tag;
    logic [NR*RW-1:0]  req_rs_tag;
    logic [NR*DW-1:0]  req_value;
    logic              flush;
    logic [NR-1:0]     grant;
    logic              cdb_valid;
    logic [TW-1:0]     cdb_tag;
    logic [RW-1:0]     cdb_rs_tag;
    logic [DW-1:0]     cdb_value;
    logic              protocol_err;

    cdb_arbiter #(.NUM_REQ(NR), .TAG_W(TW), .RS_W(RW), .DATA_W(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .req_tag      (req_tag),
        .req_rs_tag   (req_rs_tag),
        .req_value    (req_value),
        .flush        (flush),
        .grant        (grant),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_rs_tag   (cdb_rs_tag),
        .cdb_value    (cdb_value),
        .protocol_err (protocol_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          v;
        logic [TW-1:0] tag;
        logic [RW-1:0] rs;
        logic [DW-1:0] val;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state
    int            m_ptr;
    logic          m_v;
    logic [TW-1:0] m_tag;
    logic [RW-1:0] m_rs;
    logic [DW-1:0] m_val;
    logic          m_err;
    logic [NR-1:0] m_req_q;
    logic [NR-1:0] m_grant_q;
    logic          m_flush_q;

    // Per-FU result fields presented on the request bus
    logic [TW-1:0] fu_tag[NR];
    logic [RW-1:0] fu_rs[NR];
    logic [DW-1:0] fu_val[NR];
    int            gcount[NR];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr     = 0;
        m_v       = 1'b0;
        m_tag     = '0;
        m_rs      = 3'd7;
        m_val     = '0;
        m_err     = 1'b0;
        m_req_q   = '0;
        m_grant_q = '0;
        m_flush_q = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle of requests, check the combinational grant and queue the
    // broadcast the CDB must show after the coming edge.
    task automatic apply_cycle(input logic [NR-1:0] r, input logic fl, output int win);
        exp_t          e;
        logic [NR-1:0] eg;
        @(negedge clock);
        req   = r;
        flush = fl;
        for (int i = 0; i < NR; i++) begin
            req_tag[i*TW +: TW]    = fu_tag[i];
            req_rs_tag[i*RW +: RW] = fu_rs[i];
            req_value[i*DW +: DW]  = fu_val[i];
        end
        #1;
        win = -1;
        if (!fl) begin
            for (int k = 0; k < NR; k++) begin
                if (win < 0 && r[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
            end
        end
        eg = '0;
        if (win >= 0) eg[win] = 1'b1;
        check("grant", 64'(grant), 64'(eg));
        for (int i = 0; i < NR; i++) if (grant[i]) gcount[i]++;
        for (int i = 0; i < NR; i++) begin
            if (r[i] && fu_tag[i] == '0) m_err = 1'b1;
            if (m_req_q[i] && !m_grant_q[i] && !r[i] && !m_flush_q) m_err = 1'b1;
        end
        if (win >= 0) begin
            m_v   = 1'b1;
            m_tag = fu_tag[win];
            m_rs  = fu_rs[win];
            m_val = fu_val[win];
            m_ptr = (win + 1) % NR;
        end else begin
            m_v = 1'b0;
        end
        m_req_q   = r;
        m_grant_q = eg;
        m_flush_q = fl;
        e.v   = m_v;
        e.tag = m_tag;
        e.rs  = m_rs;
        e.val = m_val;
        e.err = m_err;
        sb.push_back(e);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, " cdb_valid"}, 64'(cdb_valid), 64'd0);
        check({name, " cdb_tag"}, 64'(cdb_tag), 64'd0);
        check({name, " cdb_rs_tag"}, 64'(cdb_rs_tag), 64'd7);
        check({name, " cdb_value"}, 64'(cdb_value), 64'd0);
        check({name, " protocol_err"}, 64'(protocol_err), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b1;
        req   = '0;
        flush = 1'b0;
        model_reset();
        #1;
        check_reset_vals("reset");
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic set_fu(input int i, input logic [TW-1:0] t, input logic [RW-1:0] rs,
                          input logic [DW-1:0] v);
        fu_tag[i] = t;
        fu_rs[i]  = rs;
        fu_val[i] = v;
    endtask

    // Monitor: compares each registered broadcast against the queued expectation.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (cdb_valid !== e.v || cdb_tag !== e.tag || cdb_rs_tag !== e.rs ||
                cdb_value !== e.val || protocol_err !== e.err) begin
                fails++;
                $display("FAIL cdb: got v=%0d tag=%0d rs=%0d val=%h err=%0d expected v=%0d tag=%0d rs=%0d val=%h err=%0d at %0t",
                         cdb_valid, cdb_tag, cdb_rs_tag, cdb_value, protocol_err,
                         e.v, e.tag, e.rs, e.val, e.err, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            w;
        logic [NR-1:0] pend;
        logic          fl;

        reset      = 1'b1;
        req        = '0;
        flush      = 1'b0;
        req_tag    = '0;
        req_rs_tag = '0;
        req_value  = '0;
        for (int i = 0; i < NR; i++) set_fu(i, 3'(i + 1), 3'(i), 32'h100 + 32'(i));
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_reset_vals("initial");
        check("initial grant", 64'(grant), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Single request
        set_fu(1, 3'd3, 3'd2, 32'hDEAD);
        apply_cycle(4'b0010, 1'b0, w);
        apply_cycle(4'b0000, 1'b0, w);

        // Contention from ptr 0
        do_reset();
        set_fu(1, 3'd4, 3'd1, 32'h1111);
        set_fu(3, 3'd6, 3'd5, 32'h3333);
        apply_cycle(4'b1010, 1'b0, w);
        apply_cycle(4'b1000, 1'b0, w);
        apply_cycle(4'b0000, 1'b0, w);

        // Flush cancels the grant and does not move the pointer
        set_fu(0, 3'd2, 3'd3, 32'hF00D);
        apply_cycle(4'b0001, 1'b1, w);
        apply_cycle(4'b0001, 1'b0, w);
        apply_cycle(4'b0000, 1'b0, w);

        // Fairness: all FUs requesting continuously
        do_reset();
        for (int i = 0; i < NR; i++) begin
            set_fu(i, 3'(i + 1), 3'(i + 2), 32'hA000 + 32'(i));
            gcount[i] = 0;
        end
        repeat (8) apply_cycle(4'b1111, 1'b0, w);
        for (int i = 0; i < NR; i++) check("fairness count", 64'(gcount[i]), 64'd2);
        apply_cycle(4'b1111, 1'b1, w);
        apply_cycle(4'b0000, 1'b0, w);

        // Asynchronous reset while a broadcast is on the bus
        do_reset();
        set_fu(2, 3'd5, 3'd1, 32'hCAFE);
        apply_cycle(4'b0100, 1'b0, w);
        @(posedge clock);
        #2;
        check("valid before async reset", 64'(cdb_valid), 64'd1);
        req   = '0;
        reset = 1'b1;
        sb.delete();
        #1;
        check_reset_vals("async reset");
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        set_fu(1, 3'd1, 3'd0, 32'h5555);
        set_fu(3, 3'd2, 3'd4, 32'h7777);
        apply_cycle(4'b1010, 1'b0, w);
        apply_cycle(4'b1000, 1'b0, w);
        apply_cycle(4'b0000, 1'b0, w);

        // Protocol error: zero ROB tag, then sticky
        do_reset();
        set_fu(2, 3'd0, 3'd3, 32'h2222);
        apply_cycle(4'b0100, 1'b0, w);
        set_fu(2, 3'd1, 3'd3, 32'h2222);
        repeat (3) apply_cycle(4'b0000, 1'b0, w);

        // Protocol error: request dropped without a grant
        do_reset();
        set_fu(0, 3'd3, 3'd0, 32'h0A0A);
        set_fu(1, 3'd4, 3'd1, 32'h0B0B);
        apply_cycle(4'b0011, 1'b0, w);
        apply_cycle(4'b0000, 1'b0, w);
        apply_cycle(4'b0000, 1'b0, w);

        // Randomized traffic obeying the requester contract
        do_reset();
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    set_fu(i, 3'($urandom_range(1, 7)), 3'($urandom_range(0, 6)), $urandom);
                end
            end
            fl = ($urandom_range(0, 9) == 0);
            apply_cycle(pend, fl, w);
            if (fl) pend = '0;
            else if (w >= 0) pend[w] = 1'b0;
        end
        apply_cycle(pend & 4'b0000, 1'b1, w);

        @(negedge clock);
        #2;
        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
